// File: rtl/seq_recorder.sv
// Write-side recorder: captures switch patterns into numbered RAM slots, one word per button edge.
// Optional build macro SEQ_REC_DUP_SKIP_EN: skip a step whose pattern repeats the last stored one.
module seq_recorder #(
    parameter int SLOT_W = 3,
    parameter int STEP_W = 4,
    parameter int PAT_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic                         CLK_50,
    input  logic                         reset,
    input  logic                         rec_en,
    input  logic [SLOT_W-1:0]            slot_sel,
    input  logic [PAT_W-1:0]             pattern,
    input  logic                         pb_step,
    input  logic                         pb_done,
    input  logic                         pb_clear,
    output logic [SLOT_W+STEP_W-1:0]     wraddress,
    output logic [DATA_W-1:0]            data,
    output logic                         wren,
    output logic [STEP_W:0]              step_count,
    output logic                         busy,
    output logic                         full,
    output logic                         rec_active,
    output logic                         wr_done
);
    localparam logic [DATA_W-1:0] END_WORD = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ARMED, WRITE, TERM, CLEAR} state_t;

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [STEP_W-1:0] step_idx, clr_idx, clr_nxt;
    logic              step_q, done_q, clear_q, en_q;
    logic              step_e, done_e, clear_e, en_e;
    logic              last_step, dup;

    assign step_e    = pb_step  & ~step_q;
    assign done_e    = pb_done  & ~done_q;
    assign clear_e   = pb_clear & ~clear_q;
    assign en_e      = rec_en   & ~en_q;
    assign clr_nxt   = clr_idx + 1'b1;
    assign last_step = (step_idx == {STEP_W{1'b1}});

`ifdef SEQ_REC_DUP_SKIP_EN
    logic             have_last;
    logic [PAT_W-1:0] last_pat;

    // A real write is the only WRITE cycle with wren high; its data carries the pattern.
    always_ff @(posedge CLK_50) begin
        if (reset || state == IDLE || state == CLEAR) begin
            have_last <= 1'b0;
            last_pat  <= '0;
        end else if (state == WRITE && wren) begin
            have_last <= 1'b1;
            last_pat  <= data[PAT_W-1:0];
        end
    end

    assign dup = have_last && (pattern == last_pat) && !last_step;
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state      <= IDLE;
            slot       <= '0;
            step_idx   <= '0;
            clr_idx    <= '0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
            clear_q    <= 1'b0;
            en_q       <= 1'b0;
            wraddress  <= '0;
            data       <= '0;
            wren       <= 1'b0;
            step_count <= '0;
            busy       <= 1'b0;
            full       <= 1'b0;
            rec_active <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            step_q  <= pb_step;
            done_q  <= pb_done;
            clear_q <= pb_clear;
            en_q    <= rec_en;
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_e) begin
                        slot       <= slot_sel;
                        step_idx   <= '0;
                        step_count <= '0;
                        full       <= 1'b0;
                        rec_active <= 1'b1;
                        state      <= ARMED;
                    end else if (clear_e && rec_en) begin
                        slot      <= slot_sel;
                        clr_idx   <= '0;
                        wraddress <= {slot_sel, {STEP_W{1'b0}}};
                        data      <= END_WORD;
                        wren      <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                ARMED: begin
                    if (clear_e) begin
                        clr_idx    <= '0;
                        wraddress  <= {slot, {STEP_W{1'b0}}};
                        data       <= END_WORD;
                        wren       <= 1'b1;
                        busy       <= 1'b1;
                        rec_active <= 1'b0;
                        state      <= CLEAR;
                    end else if (done_e) begin
                        wraddress  <= {slot, step_idx};
                        data       <= END_WORD;
                        wren       <= 1'b1;
                        busy       <= 1'b1;
                        rec_active <= 1'b0;
                        state      <= TERM;
                    end else if (step_e) begin
                        // A skipped duplicate still spends one WRITE cycle, just without wren.
                        if (!dup) begin
                            wraddress <= {slot, step_idx};
                            data      <= {last_step, {(DATA_W-1-PAT_W){1'b0}}, pattern};
                            wren      <= 1'b1;
                        end
                        busy       <= 1'b1;
                        rec_active <= 1'b0;
                        state      <= WRITE;
                    end else if (!rec_en) begin
                        rec_active <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WRITE: begin
                    wren <= 1'b0;
                    busy <= 1'b0;
                    if (wren) begin
                        wr_done    <= 1'b1;
                        step_count <= step_count + 1'b1;
                        if (last_step) begin
                            full  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            step_idx   <= step_idx + 1'b1;
                            rec_active <= 1'b1;
                            state      <= ARMED;
                        end
                    end else begin
                        rec_active <= 1'b1;
                        state      <= ARMED;
                    end
                end
                TERM: begin
                    wren    <= 1'b0;
                    busy    <= 1'b0;
                    wr_done <= 1'b1;
                    state   <= IDLE;
                end
                CLEAR: begin
                    if (clr_idx == {STEP_W{1'b1}}) begin
                        wren       <= 1'b0;
                        busy       <= 1'b0;
                        step_count <= '0;
                        full       <= 1'b0;
                        step_idx   <= '0;
                        rec_active <= rec_en;
                        state      <= rec_en ? ARMED : IDLE;
                    end else begin
                        clr_idx   <= clr_nxt;
                        wraddress <= {slot, clr_nxt};
                        data      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_recorder.sv
// Directed self-checking bench for seq_recorder: inputs change on negedge, outputs checked on negedge.
module tb_seq_recorder;
    logic        CLK_50 = 1'b0;
    logic        reset, rec_en, pb_step, pb_done, pb_clear;
    logic [2:0]  slot_sel;
    logic [9:0]  pattern;
    logic [6:0]  wraddress;
    logic [31:0] data;
    logic        wren, busy, full, rec_active, wr_done;
    logic [4:0]  step_count;

    int checks = 0;
    int failures = 0;

    seq_recorder dut (
        .CLK_50(CLK_50), .reset(reset), .rec_en(rec_en), .slot_sel(slot_sel),
        .pattern(pattern), .pb_step(pb_step), .pb_done(pb_done), .pb_clear(pb_clear),
        .wraddress(wraddress), .data(data), .wren(wren), .step_count(step_count),
        .busy(busy), .full(full), .rec_active(rec_active), .wr_done(wr_done)
    );

    always #5 CLK_50 = ~CLK_50;

    task automatic tick();
        @(negedge CLK_50);
    endtask

    task automatic arm(input logic [2:0] s);
        rec_en = 1'b0; tick();
        slot_sel = s; rec_en = 1'b1; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; rec_en = 0; pb_step = 0; pb_done = 0; pb_clear = 0;
        slot_sel = 0; pattern = 0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({wraddress, data, wren, step_count, busy, full, rec_active, wr_done} !== 47'd0) begin
            failures++;
            $display("FAIL reset_outputs: addr=%h data=%h wren=%b cnt=%0d busy=%b full=%b act=%b done=%b, all must be 0",
                     wraddress, data, wren, step_count, busy, full, rec_active, wr_done);
        end
    endtask

    task automatic test_single_step();
        slot_sel = 3; rec_en = 1'b1; tick();
        checks++;
        if (rec_active !== 1'b1) begin failures++; $display("FAIL arm_active: got %b want 1", rec_active); end
        pattern = 10'h155; pb_step = 1'b1; tick(); pb_step = 1'b0;
        checks++;
        if (wren !== 1'b1 || wraddress !== 7'h30 || data !== 32'h0000_0155 || busy !== 1'b1) begin
            failures++;
            $display("FAIL step1_write: wren=%b addr=%h data=%h busy=%b want 1/30/00000155/1", wren, wraddress, data, busy);
        end
        tick();
        checks++;
        if (wren !== 1'b0 || wr_done !== 1'b1 || step_count !== 5'd1 || rec_active !== 1'b1) begin
            failures++;
            $display("FAIL step1_done: wren=%b wr_done=%b cnt=%0d act=%b want 0/1/1/1", wren, wr_done, step_count, rec_active);
        end
        tick();
        checks++;
        if (wr_done !== 1'b0) begin failures++; $display("FAIL step1_done_pulse: wr_done=%b want 0", wr_done); end
    endtask

    task automatic test_step_then_done();
        pattern = 10'h2AA; pb_step = 1'b1; tick(); pb_step = 1'b0;
        checks++;
        if (wren !== 1'b1 || wraddress !== 7'h31 || data !== 32'h0000_02AA) begin
            failures++;
            $display("FAIL step2_write: wren=%b addr=%h data=%h want 1/31/000002AA", wren, wraddress, data);
        end
        tick(); tick();
        pb_done = 1'b1; tick(); pb_done = 1'b0;
        checks++;
        if (wren !== 1'b1 || wraddress !== 7'h32 || data !== 32'h8000_0000) begin
            failures++;
            $display("FAIL term_write: wren=%b addr=%h data=%h want 1/32/80000000", wren, wraddress, data);
        end
        tick();
        checks++;
        if (wren !== 1'b0 || wr_done !== 1'b1 || rec_active !== 1'b0 || step_count !== 5'd2) begin
            failures++;
            $display("FAIL term_done: wren=%b wr_done=%b act=%b cnt=%0d want 0/1/0/2", wren, wr_done, rec_active, step_count);
        end
    endtask

    task automatic test_full_slot();
        logic [31:0] exp_d;
        logic [6:0]  exp_a;
        arm(3'd0);
        for (int i = 0; i < 16; i++) begin
            pattern = 10'(i); pb_step = 1'b1; tick(); pb_step = 1'b0;
            exp_d = 32'(i);
            if (i == 15) exp_d[31] = 1'b1;
            exp_a = 7'(i);
            checks++;
            if (wren !== 1'b1 || wraddress !== exp_a || data !== exp_d) begin
                failures++;
                $display("FAIL fill_write[%0d]: wren=%b addr=%h data=%h want 1/%h/%h", i, wren, wraddress, data, exp_a, exp_d);
            end
            tick(); tick();
        end
        checks++;
        if (full !== 1'b1 || step_count !== 5'd16 || rec_active !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_end: full=%b cnt=%0d act=%b busy=%b want 1/16/0/0", full, step_count, rec_active, busy);
        end
        pb_step = 1'b1; tick(); pb_step = 1'b0;
        checks++;
        if (wren !== 1'b0) begin failures++; $display("FAIL fill_no_wrap: wren=%b want 0", wren); end
    endtask

    task automatic test_clear();
        logic [31:0] exp_d;
        arm(3'd5);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL clear_pre_busy: busy=%b want 0", busy); end
        pb_clear = 1'b1; tick(); pb_clear = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_d = (k == 0) ? 32'h8000_0000 : 32'h0;
            checks++;
            if (wren !== 1'b1 || busy !== 1'b1 || wraddress !== {3'd5, 4'(k)} || data !== exp_d) begin
                failures++;
                $display("FAIL clear_word[%0d]: wren=%b busy=%b addr=%h data=%h want 1/1/%h/%h",
                         k, wren, busy, wraddress, data, {3'd5, 4'(k)}, exp_d);
            end
            if (k == 3) pb_step = 1'b1;
            if (k == 5) pb_step = 1'b0;
            tick();
        end
        checks++;
        if (wren !== 1'b0 || busy !== 1'b0 || rec_active !== 1'b1 || step_count !== 5'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL clear_end: wren=%b busy=%b act=%b cnt=%0d full=%b want 0/0/1/0/0", wren, busy, rec_active, step_count, full);
        end
        tick();
        checks++;
        if (wren !== 1'b0 || wr_done !== 1'b0) begin
            failures++;
            $display("FAIL clear_step_dropped: wren=%b wr_done=%b want 0/0", wren, wr_done);
        end
    endtask

    task automatic test_done_priority_and_abort();
        pattern = 10'h001; pb_step = 1'b1; tick(); pb_step = 1'b0; tick(); tick();
        pattern = 10'h002; pb_step = 1'b1; tick(); pb_step = 1'b0; tick(); tick();
        pattern = 10'h3FF; pb_step = 1'b1; pb_done = 1'b1; tick(); pb_step = 1'b0; pb_done = 1'b0;
        checks++;
        if (wren !== 1'b1 || wraddress !== 7'h52 || data !== 32'h8000_0000) begin
            failures++;
            $display("FAIL done_priority: wren=%b addr=%h data=%h want 1/52/80000000", wren, wraddress, data);
        end
        tick();
        checks++;
        if (wren !== 1'b0 || rec_active !== 1'b0 || step_count !== 5'd2) begin
            failures++;
            $display("FAIL done_priority_end: wren=%b act=%b cnt=%0d want 0/0/2", wren, rec_active, step_count);
        end
        arm(3'd6);
        rec_en = 1'b0; tick();
        checks++;
        if (rec_active !== 1'b0 || wren !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort: act=%b wren=%b busy=%b want 0/0/0", rec_active, wren, busy);
        end
        tick();
        checks++;
        if (wren !== 1'b0 || step_count !== 5'd0) begin
            failures++;
            $display("FAIL abort_nowrite: wren=%b cnt=%0d want 0/0", wren, step_count);
        end
    endtask

    task automatic test_reset_mid_clear();
        int wr_seen;
        slot_sel = 3'd2; rec_en = 1'b1; tick();
        pb_clear = 1'b1; tick(); pb_clear = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1; tick();
        checks++;
        if ({wraddress, data, wren, step_count, busy, full, rec_active, wr_done} !== 47'd0) begin
            failures++;
            $display("FAIL reset_mid_clear: addr=%h data=%h wren=%b cnt=%0d busy=%b act=%b, all must be 0",
                     wraddress, data, wren, step_count, busy, rec_active);
        end
        reset = 1'b0;
        wr_seen = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (wren === 1'b1) wr_seen++;
        end
        checks++;
        if (wr_seen !== 0) begin failures++; $display("FAIL clear_not_resumed: wren cycles=%0d want 0", wr_seen); end
    endtask

    task automatic test_dup_step();
        int wr_seen, done_seen, exp_n;
`ifdef SEQ_REC_DUP_SKIP_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        arm(3'd1);
        wr_seen = 0; done_seen = 0;
        for (int p = 0; p < 2; p++) begin
            pattern = 10'h0F0; pb_step = 1'b1; tick(); pb_step = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (wren === 1'b1) wr_seen++;
                if (wr_done === 1'b1) done_seen++;
                tick();
            end
        end
        checks++;
        if (wr_seen !== exp_n || done_seen !== exp_n || step_count !== 5'(exp_n)) begin
            failures++;
            $display("FAIL dup_step: writes=%0d done=%0d cnt=%0d want %0d each", wr_seen, done_seen, step_count, exp_n);
        end
        checks++;
        if (rec_active !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dup_step_armed: act=%b busy=%b want 1/0", rec_active, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_step_then_done();
        test_full_slot();
        test_clear();
        test_done_priority_and_abort();
        test_reset_mid_clear();
        test_dup_step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
